// File: rtl/dpb_slot_scheduler.sv
// dpb_slot_scheduler: queues completed DPB slot descriptors from the slot
// writer and issues them one at a time to the DDR3 write master using a
// level request / pulse done handshake. Reports free-slot credit, counts
// dispatched frames, and flags overflow and abandoned (timed-out) transfers.
// Optional build macro DPB_SCHED_SEQ_CHECK_EN adds o_seq_err, a sticky flag
// raised when an accepted slot rank does not follow the previous one.
module dpb_slot_scheduler #(
   parameter int SLOT_NUM      = 16,
   parameter int TIMEOUT_CYC   = 65535,
   parameter int FRAME_MAX_128 = 91
) (
   input  logic        i_pclk,
   input  logic        i_rst_n,
   input  logic        i_wr_req,
   input  logic [3:0]  i_wr_rank,
   input  logic [6:0]  i_wr_128cnt,
   input  logic [5:0]  i_wr_bytecnt,
   input  logic        i_wr_last,
   output logic        o_wr_ready,
   output logic        o_rd_req,
   output logic [3:0]  o_rd_rank,
   output logic [6:0]  o_rd_128cnt,
   output logic [5:0]  o_rd_bytecnt,
   output logic        o_rd_last,
   input  logic        i_rd_done,
   output logic [4:0]  o_free_cnt,
   output logic [15:0] o_frame_cnt,
   output logic        o_overflow,
   output logic        o_timeout
`ifdef DPB_SCHED_SEQ_CHECK_EN
   ,
   output logic        o_seq_err
`endif
);

   localparam int PTR_W = $clog2(SLOT_NUM);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOT_NUM);
   localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(SLOT_NUM - 1);
   localparam logic [4:0]       SLOT_NUM5 = 5'(SLOT_NUM);
   localparam logic [6:0]       FMAX      = 7'(FRAME_MAX_128);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_DONE, ST_RELEASE} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              req_q, req_d;
   logic [3:0]        rank_q, rank_d;
   logic [6:0]        cnt128_q, cnt128_d;
   logic [5:0]        bytes_q, bytes_d;
   logic              last_q, last_d;
   logic              wr_ready_q, wr_ready_d;
   logic [4:0]        free_q, free_d;
   logic [15:0]       frame_q, frame_d;
   logic              ovf_q, ovf_d;
   logic              to_q, to_d;
   logic [17:0]       mem_q [SLOT_NUM];

   logic              push_ok;
   logic              pop;
   logic [17:0]       wr_desc;
   logic [17:0]       head_desc;

   // Push acceptance and descriptor packing, word count clamped to the slot size
   always_comb begin
      push_ok   = i_wr_req && (count_q < FULL_CNT);
      wr_desc   = {i_wr_rank,
                   (i_wr_128cnt > FMAX) ? FMAX : i_wr_128cnt,
                   i_wr_bytecnt,
                   i_wr_last};
      head_desc = mem_q[rptr_q];
   end

   // Descriptor storage; contents need no reset because count gates every read
   always_ff @(posedge i_pclk) begin
      if (push_ok) mem_q[wptr_q] <= wr_desc;
   end

   // Dispatch FSM: issue head descriptor, wait for done or timeout, one release cycle
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      rank_d   = rank_q;
      cnt128_d = cnt128_q;
      bytes_d  = bytes_q;
      last_d   = last_q;
      tcnt_d   = tcnt_q;
      frame_d  = frame_q;
      to_d     = to_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               {rank_d, cnt128_d, bytes_d, last_d} = head_desc;
               req_d   = 1'b1;
               tcnt_d  = '0;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            // A done arriving on the timeout cycle wins over the timeout
            if (i_rd_done) begin
               req_d   = 1'b0;
               pop     = 1'b1;
               state_d = ST_RELEASE;
               if (last_q) frame_d = frame_q + 16'd1;
            end else if (tcnt_q == TO_LAST) begin
               req_d   = 1'b0;
               pop     = 1'b1;
               to_d    = 1'b1;
               state_d = ST_RELEASE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // FIFO pointers, occupancy and the writer-facing credit flags
   always_comb begin
      wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop     ? rptr_q + 1'b1 : rptr_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      ovf_d      = ovf_q | (i_wr_req & ~push_ok);
      // One slot stays reserved for the slot the writer is currently filling
      wr_ready_d = (count_d < READY_LIM);
      free_d     = SLOT_NUM5 - 5'(count_d);
   end

   // State and control registers
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         tcnt_q     <= '0;
         req_q      <= 1'b0;
         rank_q     <= '0;
         cnt128_q   <= '0;
         bytes_q    <= '0;
         last_q     <= 1'b0;
         wr_ready_q <= 1'b1;
         free_q     <= SLOT_NUM5;
         frame_q    <= '0;
         ovf_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         tcnt_q     <= tcnt_d;
         req_q      <= req_d;
         rank_q     <= rank_d;
         cnt128_q   <= cnt128_d;
         bytes_q    <= bytes_d;
         last_q     <= last_d;
         wr_ready_q <= wr_ready_d;
         free_q     <= free_d;
         frame_q    <= frame_d;
         ovf_q      <= ovf_d;
         to_q       <= to_d;
      end
   end

`ifdef DPB_SCHED_SEQ_CHECK_EN
   localparam logic [3:0] RANK_MASK = 4'(SLOT_NUM - 1);

   logic [3:0] exp_rank_q, exp_rank_d;
   logic       seq_err_q, seq_err_d;

   // Rank sequence tracking resynchronises to the actual rank so one skip flags once
   always_comb begin
      exp_rank_d = exp_rank_q;
      seq_err_d  = seq_err_q;
      if (push_ok) begin
         if (i_wr_rank != exp_rank_q) seq_err_d = 1'b1;
         exp_rank_d = (i_wr_rank + 4'd1) & RANK_MASK;
      end
   end

   // Sequence checker registers
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         exp_rank_q <= '0;
         seq_err_q  <= 1'b0;
      end else begin
         exp_rank_q <= exp_rank_d;
         seq_err_q  <= seq_err_d;
      end
   end

   assign o_seq_err = seq_err_q;
`endif

   assign o_wr_ready   = wr_ready_q;
   assign o_rd_req     = req_q;
   assign o_rd_rank    = rank_q;
   assign o_rd_128cnt  = cnt128_q;
   assign o_rd_bytecnt = bytes_q;
   assign o_rd_last    = last_q;
   assign o_free_cnt   = free_q;
   assign o_frame_cnt  = frame_q;
   assign o_overflow   = ovf_q;
   assign o_timeout    = to_q;

endmodule

// File: tb/tb_dpb_slot_scheduler.sv
// Testbench for dpb_slot_scheduler: directed scenarios plus a randomized
// phase, with a queue-based reference model and a scoreboard monitor.
// Build with DPB_SCHED_SEQ_CHECK_EN defined to also exercise o_seq_err.
module tb_dpb_slot_scheduler;

   localparam int SLOTS = 16;
   localparam int TO    = 100;
   localparam int FMAX  = 91;

   typedef struct packed {
      logic [3:0] rank;
      logic [6:0] cnt;
      logic [5:0] bytes;
      logic       last;
   } desc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_wr_req = 1'b0;
   logic [3:0]  i_wr_rank = '0;
   logic [6:0]  i_wr_128cnt = '0;
   logic [5:0]  i_wr_bytecnt = '0;
   logic        i_wr_last = 1'b0;
   logic        i_rd_done = 1'b0;
   logic        o_wr_ready, o_rd_req, o_rd_last, o_overflow, o_timeout;
   logic [3:0]  o_rd_rank;
   logic [6:0]  o_rd_128cnt;
   logic [5:0]  o_rd_bytecnt;
   logic [4:0]  o_free_cnt;
   logic [15:0] o_frame_cnt;
`ifdef DPB_SCHED_SEQ_CHECK_EN
   logic        o_seq_err;
`endif

   always #5 clk = ~clk;

   dpb_slot_scheduler #(.SLOT_NUM(SLOTS), .TIMEOUT_CYC(TO), .FRAME_MAX_128(FMAX)) dut (
      .i_pclk(clk), .i_rst_n(rst_n),
      .i_wr_req(i_wr_req), .i_wr_rank(i_wr_rank), .i_wr_128cnt(i_wr_128cnt),
      .i_wr_bytecnt(i_wr_bytecnt), .i_wr_last(i_wr_last),
      .o_wr_ready(o_wr_ready), .o_rd_req(o_rd_req), .o_rd_rank(o_rd_rank),
      .o_rd_128cnt(o_rd_128cnt), .o_rd_bytecnt(o_rd_bytecnt), .o_rd_last(o_rd_last),
      .i_rd_done(i_rd_done), .o_free_cnt(o_free_cnt), .o_frame_cnt(o_frame_cnt),
      .o_overflow(o_overflow), .o_timeout(o_timeout)
`ifdef DPB_SCHED_SEQ_CHECK_EN
      , .o_seq_err(o_seq_err)
`endif
   );

   int          n_tests = 0;
   int          n_fail  = 0;

   // reference model state
   desc_t       model_q[$];
   desc_t       exp_q[$];
   desc_t       cur_exp;
   logic        req_s = 1'b0;
   logic        drop_exp = 1'b0;
   int          wcnt = 0;
   logic        ovf_m = 1'b0, to_m = 1'b0, seq_m = 1'b0;
   logic [15:0] frm_m = '0;
   logic [3:0]  exp_rank_m = '0;

   // responder controls
   logic        ack_en = 1'b0, ack_rand = 1'b0, spur_en = 1'b0;
   int          ack_dly = 3;
   int          ack_c = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic desc_t mk(input logic [3:0] r, input logic [6:0] c,
                                input logic [5:0] b, input logic l);
      desc_t d;
      d.rank  = r;
      d.cnt   = (int'(c) > FMAX) ? 7'(FMAX) : c;
      d.bytes = b;
      d.last  = l;
      return d;
   endfunction

   // Reference model: queue of stored slots, rules applied per clock edge
   always @(posedge clk or negedge rst_n) begin : model
      desc_t d;
      logic  full;
      if (!rst_n) begin
         model_q.delete();
         exp_q.delete();
         wcnt = 0; ovf_m = 0; to_m = 0; frm_m = '0; exp_rank_m = '0; seq_m = 0;
         drop_exp = 0;
      end else begin
         full = (model_q.size() >= SLOTS);
         drop_exp = 0;
         if (req_s) begin
            wcnt++;
            if (model_q.size() == 0) begin
               bound_fail("req_with_empty_queue");
            end else if (i_rd_done) begin
               if (model_q[0].last) frm_m++;
               void'(model_q.pop_front());
               drop_exp = 1;
            end else if (wcnt == TO) begin
               to_m = 1;
               void'(model_q.pop_front());
               drop_exp = 1;
            end
         end else begin
            wcnt = 0;
         end
         if (i_wr_req) begin
            if (full) ovf_m = 1;
            else begin
               d = mk(i_wr_rank, i_wr_128cnt, i_wr_bytecnt, i_wr_last);
               model_q.push_back(d);
               exp_q.push_back(d);
               if (i_wr_rank != exp_rank_m) seq_m = 1;
               exp_rank_m = i_wr_rank + 4'd1;
            end
         end
      end
   end

   // Monitor / scoreboard: checks each issued request and status outputs
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_rd_req && !req_s) begin
            if (exp_q.size() == 0) bound_fail("unexpected_request");
            else begin
               cur_exp = exp_q.pop_front();
               chk("req_rank",  o_rd_rank,    cur_exp.rank);
               chk("req_cnt",   o_rd_128cnt,  cur_exp.cnt);
               chk("req_bytes", o_rd_bytecnt, cur_exp.bytes);
               chk("req_last",  o_rd_last,    cur_exp.last);
            end
         end else if (o_rd_req) begin
            chk("hold_fields", {o_rd_rank, o_rd_128cnt, o_rd_bytecnt, o_rd_last}, cur_exp);
         end
         if (drop_exp) chk("req_drop", o_rd_req, 1'b0);
         chk("free_cnt",  o_free_cnt,  SLOTS - model_q.size());
         chk("wr_ready",  o_wr_ready,  model_q.size() < SLOTS - 1);
         chk("overflow",  o_overflow,  ovf_m);
         chk("timeout",   o_timeout,   to_m);
         chk("frame_cnt", o_frame_cnt, frm_m);
`ifdef DPB_SCHED_SEQ_CHECK_EN
         chk("seq_err",   o_seq_err,   seq_m);
`endif
      end
      req_s = o_rd_req;
   end

   // DDR3 master stand-in: acks after ack_dly cycles, optional stray dones
   always @(negedge clk) begin
      i_rd_done = 1'b0;
      if (rst_n && o_rd_req && ack_en) begin
         ack_c++;
         if (ack_c >= ack_dly) begin
            i_rd_done = 1'b1;
            ack_c = 0;
            if (ack_rand) ack_dly = $urandom_range(1, 20);
         end
      end else begin
         ack_c = 0;
         if (rst_n && spur_en && !o_rd_req && $urandom_range(0, 9) == 0) i_rd_done = 1'b1;
      end
   end

   task automatic push(input logic [3:0] r, input logic [6:0] c, input logic [5:0] b, input logic l);
      @(negedge clk);
      i_wr_req = 1'b1; i_wr_rank = r; i_wr_128cnt = c; i_wr_bytecnt = b; i_wr_last = l;
      @(negedge clk);
      i_wr_req = 1'b0;
   endtask

   task automatic wait_req(input logic lvl, input int bound, input string name);
      int cyc;
      cyc = 0;
      while (o_rd_req !== lvl && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      if (o_rd_req !== lvl) bound_fail(name);
   endtask

   task automatic wait_drain(input int bound, input string name);
      int cyc;
      cyc = 0;
      while ((model_q.size() != 0 || o_rd_req) && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      if (model_q.size() != 0 || o_rd_req) bound_fail(name);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_req", o_rd_req, 0);
      chk("rst_fields", {o_rd_rank, o_rd_128cnt, o_rd_bytecnt, o_rd_last}, 0);
      chk("rst_free", o_free_cnt, SLOTS);
      chk("rst_ready", o_wr_ready, 1);
      chk("rst_frame", o_frame_cnt, 0);
      chk("rst_flags", {o_overflow, o_timeout}, 0);
      #2 rst_n = 1'b1;

      // single slot and issue latency
      push(4'd0, 7'd91, 6'd0, 1'b0);
      chk("lat_one_cycle", o_rd_req, 0);
      @(negedge clk);
      chk("lat_two_cycles", o_rd_req, 1);
      chk("single_rank", o_rd_rank, 0);
      chk("single_cnt", o_rd_128cnt, 91);
      @(posedge clk);
      ack_dly = 3; ack_en = 1'b1;
      wait_drain(50, "single_drain");
      chk("single_free", o_free_cnt, SLOTS);

      // frame count across three slots
      ack_dly = 10;
      push(4'd1, 7'd10, 6'd1, 1'b0);
      push(4'd2, 7'd20, 6'd2, 1'b0);
      push(4'd3, 7'd30, 6'd3, 1'b1);
      wait_drain(200, "frame_drain");
      chk("frame_one", o_frame_cnt, 1);
      chk("frame_no_timeout", o_timeout, 0);

      // timeout: request abandoned after TO cycles
      ack_en = 1'b0;
      push(4'd5, 7'd50, 6'd7, 1'b1);
      wait_req(1'b1, 10, "timeout_req_rise");
      cyc = 0;
      while (o_rd_req && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("timeout_len", cyc, TO);
      chk("timeout_flag", o_timeout, 1);
      chk("timeout_frame", o_frame_cnt, 1);
      chk("timeout_empty", o_free_cnt, SLOTS);

      // fill to full, then overflow
      for (int i = 0; i < SLOTS; i++) begin
         push(4'(i + 6), 7'(i * 5), 6'(i), 1'b0);
         if (i == SLOTS - 3) chk("ready_at_14", o_wr_ready, 1);
         if (i == SLOTS - 2) chk("ready_low_at_15", o_wr_ready, 0);
      end
      chk("full_free", o_free_cnt, 0);
      chk("full_no_ovf", o_overflow, 0);
      push(4'd7, 7'd1, 6'd1, 1'b0);
      chk("ovf_set", o_overflow, 1);
      chk("ovf_free", o_free_cnt, 0);
      ack_dly = 2; ack_en = 1'b1;
      wait_drain(400, "full_drain");

      // simultaneous push and done with one slot queued
      ack_en = 1'b0;
      push(4'd4, 7'd12, 6'd3, 1'b0);
      wait_req(1'b1, 10, "simul_req_rise");
      @(posedge clk);
      ack_dly = 1; ack_en = 1'b1;
      push(4'd9, 7'd33, 6'd5, 1'b0);
      ack_en = 1'b0;
      chk("simul_free", o_free_cnt, SLOTS - 1);
      wait_req(1'b1, 10, "simul_next_req");
      chk("simul_rank", o_rd_rank, 9);
      chk("simul_cnt", o_rd_128cnt, 33);
      ack_dly = 2; ack_en = 1'b1;
      wait_drain(50, "simul_drain");

      // asynchronous reset during WAIT_DONE
      ack_en = 1'b0;
      push(4'd2, 7'd5, 6'd0, 1'b0);
      push(4'd3, 7'd6, 6'd0, 1'b0);
      wait_req(1'b1, 10, "arst_req_rise");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", o_rd_req, 0);
      chk("arst_free", o_free_cnt, SLOTS);
      chk("arst_ready", o_wr_ready, 1);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // randomized traffic
      ack_rand = 1'b1; ack_dly = 5; spur_en = 1'b1; ack_en = 1'b1;
      begin
         logic [3:0] nr;
         nr = '0;
         for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 35) begin
               i_wr_req     = 1'b1;
               i_wr_rank    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : nr;
               nr           = i_wr_rank + 4'd1;
               i_wr_128cnt  = 7'($urandom_range(0, 127));
               i_wr_bytecnt = 6'($urandom_range(0, 63));
               i_wr_last    = ($urandom_range(0, 3) == 0);
            end else begin
               i_wr_req = 1'b0;
            end
         end
      end
      @(negedge clk);
      i_wr_req = 1'b0;
      spur_en = 1'b0;
      wait_drain(2000, "random_drain");

`ifdef DPB_SCHED_SEQ_CHECK_EN
      // rank sequence checking
      ack_rand = 1'b0; ack_dly = 2; ack_en = 1'b1;
      do_reset();
      push(4'd0, 7'd1, 6'd0, 1'b0);
      chk("seq_r0", o_seq_err, 0);
      push(4'd1, 7'd1, 6'd0, 1'b0);
      chk("seq_r1", o_seq_err, 0);
      push(4'd3, 7'd1, 6'd0, 1'b0);
      chk("seq_r3", o_seq_err, 1);
      push(4'd4, 7'd1, 6'd0, 1'b0);
      chk("seq_r4", o_seq_err, 1);
      wait_drain(100, "seq_drain1");
      do_reset();
      for (int i = 0; i < 17; i++) push(4'(i), 7'd2, 6'd0, 1'b0);
      chk("seq_wrap", o_seq_err, 0);
      wait_drain(300, "seq_drain2");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
